// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with hardwired-zero entry 0 and a clear sequencer.
// Define REGFILE_BYPASS_EN to forward a committing write straight to matching read ports.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e            stateQ;
    logic [ADDR_W-1:0] ptrQ;
    logic              readyQ;
    logic              busyQ;
    logic              doneQ;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wrCommit;

    assign wrCommit = wr_en && readyQ && (wr_addr != '0);
    assign wr_ready = readyQ;
    assign clr_busy = busyQ;
    assign clr_done = doneQ;

    // Status outputs are registered alongside the state so nothing depends on clr_req combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            ptrQ   <= FirstAddr;
            readyQ <= 1'b1;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (clr_req) begin
                        stateQ <= StClear;
                        ptrQ   <= FirstAddr;
                        readyQ <= 1'b0;
                        busyQ  <= 1'b1;
                    end
                end
                StClear: begin
                    if (ptrQ == LastAddr) begin
                        stateQ <= StDone;
                        busyQ  <= 1'b0;
                        doneQ  <= 1'b1;
                    end else begin
                        ptrQ <= ptrQ + FirstAddr;
                    end
                end
                StDone: begin
                    stateQ <= StIdle;
                    ptrQ   <= FirstAddr;
                    readyQ <= 1'b1;
                    doneQ  <= 1'b0;
                end
                default: begin
                    stateQ <= StIdle;
                    ptrQ   <= FirstAddr;
                    readyQ <= 1'b1;
                    busyQ  <= 1'b0;
                    doneQ  <= 1'b0;
                end
            endcase
        end
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busyQ) begin
            mem[ptrQ] <= '0;
        end else if (wrCommit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : genRead
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;

        assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
        assign stored = (addr == '0) ? '0 : mem[addr];
`ifdef REGFILE_BYPASS_EN
        // wrCommit already excludes address 0, so forwarding never disturbs the zero register.
        assign rd_data[k*DATA_W +: DATA_W] = (wrCommit && (addr == wr_addr)) ? wr_data : stored;
`else
        assign rd_data[k*DATA_W +: DATA_W] = stored;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default instance plus a narrow 4-read-port instance.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DW4 = 16;
    localparam int AW4 = 3;
    localparam int NR4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR*AW-1:0]   rdAddr;
    logic [NR*DW-1:0]   rdData;
    logic               wrEn;
    logic [AW-1:0]      wrAddr;
    logic [DW-1:0]      wrData;
    logic               wrReady, clrReq, clrBusy, clrDone;

    logic [NR4*AW4-1:0] rdAddr4;
    logic [NR4*DW4-1:0] rdData4;
    logic               wrEn4;
    logic [AW4-1:0]     wrAddr4;
    logic [DW4-1:0]     wrData4;
    logic               wrReady4, clrReq4, clrBusy4, clrDone4;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rdAddr), .rd_data(rdData),
        .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_ready(wrReady),
        .clr_req(clrReq), .clr_busy(clrBusy), .clr_done(clrDone)
    );

    regfile_mp #(.DATA_W(DW4), .ADDR_W(AW4), .NUM_RD(NR4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rdAddr4), .rd_data(rdData4),
        .wr_en(wrEn4), .wr_addr(wrAddr4), .wr_data(wrData4), .wr_ready(wrReady4),
        .clr_req(clrReq4), .clr_busy(clrBusy4), .clr_done(clrDone4)
    );

    // kind: 0 read / 1 ready / 2 busy / 3 done on dut; 4..7 the same on dut4
    typedef struct {
        int          kind;
        int          port;
        logic [31:0] value;
        string       name;
    } exp_t;

    exp_t sbQ[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] getActual(int kind, int port);
        case (kind)
            0:       return rdData[port*DW +: DW];
            1:       return {31'b0, wrReady};
            2:       return {31'b0, clrBusy};
            3:       return {31'b0, clrDone};
            4:       return {16'b0, rdData4[port*DW4 +: DW4]};
            5:       return {31'b0, wrReady4};
            6:       return {31'b0, clrBusy4};
            default: return {31'b0, clrDone4};
        endcase
    endfunction

    // Monitor: drains every expectation queued for the current cycle away from the clock edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sbQ.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = sbQ.pop_front();
                act = getActual(e.kind, e.port);
                checks++;
                if (act !== e.value) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.value);
                end
            end
        end
    end

    // Watchdog: the stimulus must finish well within this bound.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: stimulus did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expectVal(string name, int kind, int port, logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.value = v;
        e.name = name;
        sbQ.push_back(e);
    endtask

    task automatic expCtl(string name, int sel, logic r, logic b, logic d);
        int base;
        base = (sel != 0) ? 4 : 0;
        expectVal({name, ".wr_ready"}, base + 1, 0, {31'b0, r});
        expectVal({name, ".clr_busy"}, base + 2, 0, {31'b0, b});
        expectVal({name, ".clr_done"}, base + 3, 0, {31'b0, d});
    endtask

    task automatic setRd(int p, int a);
        rdAddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic setRd4(int p, int a);
        rdAddr4[p*AW4 +: AW4] = AW4'(a);
    endtask

    task automatic write(int a, logic [31:0] d);
        wrEn = 1'b1;
        wrAddr = AW'(a);
        wrData = d;
        step();
        wrEn = 1'b0;
    endtask

    initial begin
        logic [31:0] exp0;
        logic [15:0] exp4;
        rdAddr = '0; wrEn = 1'b0; wrAddr = '0; wrData = '0; clrReq = 1'b0;
        rdAddr4 = '0; wrEn4 = 1'b0; wrAddr4 = '0; wrData4 = '0; clrReq4 = 1'b0;

        // Reset values while rst_n is held low
        step();
        checks++;
        if (wrReady !== 1'b1 || clrBusy !== 1'b0 || clrDone !== 1'b0 || rdData !== '0 ||
            wrReady4 !== 1'b1 || clrBusy4 !== 1'b0 || clrDone4 !== 1'b0 || rdData4 !== '0) begin
            failures++;
            $display("FAIL reset.direct: ready=%b busy=%b done=%b rd=0x%h ready4=%b busy4=%b done4=%b rd4=0x%h",
                     wrReady, clrBusy, clrDone, rdData, wrReady4, clrBusy4, clrDone4, rdData4);
        end
        expCtl("reset", 0, 1'b1, 1'b0, 1'b0);
        expCtl("reset4", 1, 1'b1, 1'b0, 1'b0);
        setRd(0, 5); setRd(1, 31);
        expectVal("reset.rd0", 0, 0, 32'h0);
        expectVal("reset.rd1", 0, 1, 32'h0);
        step();
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            setRd(0, a); setRd(1, 31 - a);
            expectVal($sformatf("init.p0.a%0d", a), 0, 0, 32'h0);
            expectVal($sformatf("init.p1.a%0d", 31 - a), 0, 1, 32'h0);
            if (a == 0) expCtl("idle", 0, 1'b1, 1'b0, 1'b0);
            step();
        end

        // Plain write, then a discarded write to address 0
        write(5, 32'hDEADBEEF);
        write(0, 32'h12345678);
        setRd(0, 5); setRd(1, 0);
        expectVal("wr.a5", 0, 0, 32'hDEADBEEF);
        expectVal("wr.a0", 0, 1, 32'h0);
        step();

        // Same-cycle write/read on address 7
        write(7, 32'h11111111);
        wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hA5A5A5A5;
        setRd(0, 7); setRd(1, 5);
`ifdef REGFILE_BYPASS_EN
        expectVal("bypass.same", 0, 0, 32'hA5A5A5A5);
`else
        expectVal("bypass.same", 0, 0, 32'h11111111);
`endif
        expectVal("bypass.other", 0, 1, 32'hDEADBEEF);
        step();
        wrEn = 1'b0;
        expectVal("bypass.next", 0, 0, 32'hA5A5A5A5);
        step();

        // Fill and clear, with a dropped write mid-clear
        for (int a = 1; a < 32; a++) write(a, 32'(a) * 32'h01010101);
        setRd(0, 31); setRd(1, 3);
        expectVal("fill.a31", 0, 0, 32'h1F1F1F1F);
        expectVal("fill.a3", 0, 1, 32'h03030303);
        clrReq = 1'b1;
        step();
        clrReq = 1'b0;
        for (int i = 0; i < 31; i++) begin
            setRd(0, i); setRd(1, i + 1);
            expCtl($sformatf("clr.c%0d", i), 0, 1'b0, 1'b1, 1'b0);
            expectVal($sformatf("clr.passed%0d", i), 0, 0, 32'h0);
            expectVal($sformatf("clr.ahead%0d", i + 1), 0, 1, 32'(i + 1) * 32'h01010101);
            if (i == 5) begin
                wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'hFFFFFFFF;
            end else begin
                wrEn = 1'b0;
            end
            step();
        end
        wrEn = 1'b0;
        expCtl("clr.done", 0, 1'b0, 1'b0, 1'b1);
        step();
        expCtl("clr.idle", 0, 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 32; a++) begin
            setRd(0, a); setRd(1, 31 - a);
            expectVal($sformatf("post.p0.a%0d", a), 0, 0, 32'h0);
            expectVal($sformatf("post.p1.a%0d", 31 - a), 0, 1, 32'h0);
            step();
        end

        // Reset in the middle of a clear
        write(9, 32'h99999999);
        write(20, 32'h20202020);
        clrReq = 1'b1;
        step();
        clrReq = 1'b0;
        repeat (10) step();
        setRd(0, 9); setRd(1, 20);
        expCtl("abort.before", 0, 1'b0, 1'b1, 1'b0);
        expectVal("abort.a20.before", 0, 1, 32'h20202020);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        expCtl("abort.rst", 0, 1'b1, 1'b0, 1'b0);
        expectVal("abort.a9", 0, 0, 32'h0);
        expectVal("abort.a20", 0, 1, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 35; i++) begin
            expCtl($sformatf("abort.after%0d", i), 0, 1'b1, 1'b0, 1'b0);
            step();
        end
        expectVal("abort.a20.after", 0, 1, 32'h0);
        step();

        // Narrow 4-port instance
        for (int a = 1; a < 8; a++) begin
            wrEn4 = 1'b1; wrAddr4 = AW4'(a); wrData4 = 16'(a) * 16'h1111;
            step();
        end
        wrEn4 = 1'b0;
        setRd4(0, 1); setRd4(1, 3); setRd4(2, 5); setRd4(3, 7);
        expectVal("n4.p0", 4, 0, 32'h1111);
        expectVal("n4.p1", 4, 1, 32'h3333);
        expectVal("n4.p2", 4, 2, 32'h5555);
        expectVal("n4.p3", 4, 3, 32'h7777);
        step();
        setRd4(0, 7); setRd4(1, 6); setRd4(2, 2); setRd4(3, 0);
        expectVal("n4.q0", 4, 0, 32'h7777);
        expectVal("n4.q1", 4, 1, 32'h6666);
        expectVal("n4.q2", 4, 2, 32'h2222);
        expectVal("n4.q3", 4, 3, 32'h0);
        step();
        // Write and clear request on the same edge
        wrEn4 = 1'b1; wrAddr4 = 3'd4; wrData4 = 16'hBEEF; clrReq4 = 1'b1;
        step();
        wrEn4 = 1'b0; clrReq4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            setRd4(0, 4); setRd4(1, 7); setRd4(2, i); setRd4(3, i + 1);
            expCtl($sformatf("n4.clr%0d", i), 1, 1'b0, 1'b1, 1'b0);
            expectVal($sformatf("n4.a4.c%0d", i), 4, 0, (i <= 3) ? 32'hBEEF : 32'h0);
            expectVal($sformatf("n4.a7.c%0d", i), 4, 1, 32'h7777);
            expectVal($sformatf("n4.passed%0d", i), 4, 2, 32'h0);
            exp4 = (i + 1 == 4) ? 16'hBEEF : 16'(i + 1) * 16'h1111;
            expectVal($sformatf("n4.ahead%0d", i + 1), 4, 3, {16'h0, exp4});
            step();
        end
        expCtl("n4.done", 1, 1'b0, 1'b0, 1'b1);
        step();
        expCtl("n4.idle", 1, 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) setRd4(a, a + 4);
        for (int a = 0; a < 4; a++) expectVal($sformatf("n4.post%0d", a + 4), 4, a, 32'h0);
        step();
        for (int a = 0; a < 4; a++) setRd4(a, a);
        for (int a = 0; a < 4; a++) expectVal($sformatf("n4.post%0d", a), 4, a, 32'h0);
        exp0 = 32'h0;
        setRd(0, 7);
        expectVal("final.a7", 0, 0, exp0);
        step();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
